// File: rtl/iterative_comparator_if.sv
// rtl/iterative_comparator_if.sv - operand/result handshake bundle for iterative_comparator
interface iterative_comparator_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       cmp_op;
   logic             out_valid;
   logic             out_ready;
   logic             result;
   logic             err;
   logic             busy;

   modport master (
      output in_valid, a, b, cmp_op, out_ready,
      input  in_ready, out_valid, result, err, busy
   );

   modport slave (
      input  in_valid, a, b, cmp_op, out_ready,
      output in_ready, out_valid, result, err, busy
   );
endinterface

// File: rtl/iterative_comparator.sv
// rtl/iterative_comparator.sv - MSB-first slice-wise comparator for the six branch conditions
// Optional macro CMP_FIXED_LATENCY_EN: disable early exit, always scan every slice.
module iterative_comparator #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   iterative_comparator_if.slave  bus
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0]  TOP_IDX  = IDXW'(NCHUNK - 1);
   localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [2:0]       r_op;
   logic [IDXW-1:0]  r_idx;
   logic             r_out_valid;
   logic             r_result;
   logic             r_err;
`ifdef CMP_FIXED_LATENCY_EN
   logic             r_found;
   logic             r_lt_first;
`endif

   logic             w_signed;
   logic             w_flip;
   logic [CHUNK-1:0] w_sa;
   logic [CHUNK-1:0] w_sb;
   logic             w_diff;
   logic             w_lt;

   // Flipping the sign bit of the top slice turns a signed compare into an unsigned one.
   assign w_signed = (r_op == 3'b100) || (r_op == 3'b101);
   assign w_flip   = w_signed && (r_idx == TOP_IDX);
   assign w_sa     = r_a[r_idx*CHUNK +: CHUNK] ^ (w_flip ? MSB_MASK : '0);
   assign w_sb     = r_b[r_idx*CHUNK +: CHUNK] ^ (w_flip ? MSB_MASK : '0);
   assign w_diff   = (w_sa != w_sb);
   assign w_lt     = (w_sa < w_sb);

   function automatic logic map_result(input logic [2:0] op, input logic eq, input logic lt);
      logic r;
      r = 1'b0;
      case (op)
         3'b000:                 r = eq;
         3'b001:                 r = !eq;
         3'b100, 3'b110:         r = lt;
         3'b101, 3'b111:         r = !lt;
         default:                r = 1'b0;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_op        <= '0;
         r_idx       <= '0;
         r_out_valid <= 1'b0;
         r_result    <= 1'b0;
         r_err       <= 1'b0;
`ifdef CMP_FIXED_LATENCY_EN
         r_found     <= 1'b0;
         r_lt_first  <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_a      <= bus.a;
                  r_b      <= bus.b;
                  r_op     <= bus.cmp_op;
                  r_idx    <= TOP_IDX;
                  r_result <= 1'b0;
`ifdef CMP_FIXED_LATENCY_EN
                  r_found    <= 1'b0;
                  r_lt_first <= 1'b0;
`endif
                  // Illegal ops spend one cycle in DONE before out_valid, matching a one-slice scan.
                  if (bus.cmp_op[2:1] == 2'b01) begin
                     r_err   <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_err   <= 1'b0;
                     r_state <= S_SCAN;
                  end
               end
            end
            S_SCAN: begin
`ifdef CMP_FIXED_LATENCY_EN
               if (w_diff && !r_found) begin
                  r_found    <= 1'b1;
                  r_lt_first <= w_lt;
               end
               if (r_idx == '0) begin
                  r_result    <= map_result(r_op, !(r_found || w_diff), r_found ? r_lt_first : w_lt);
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_idx <= r_idx - 1'b1;
               end
`else
               if (w_diff || (r_idx == '0)) begin
                  r_result    <= map_result(r_op, !w_diff, w_lt);
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_idx <= r_idx - 1'b1;
               end
`endif
            end
            S_DONE: begin
               if (!r_out_valid) begin
                  r_out_valid <= 1'b1;
               end else if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == S_IDLE);
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.out_valid = r_out_valid;
   assign bus.result    = r_result;
   assign bus.err       = r_err;
endmodule

// File: tb/tb_iterative_comparator.sv
// tb/tb_iterative_comparator.sv - scoreboard bench for iterative_comparator
module tb_iterative_comparator;
   localparam int WIDTH  = 32;
   localparam int CHUNK  = 8;
   localparam int NCHUNK = WIDTH / CHUNK;

   typedef struct {
      logic  result;
      logic  err;
      int    lat;
      string tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb_q[$];

   iterative_comparator_if #(.WIDTH(WIDTH)) bus ();

   iterative_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input string tag);
      exp_t e;
      bit   found;
      e.tag = tag;
      e.err = 1'b0;
      e.result = 1'b0;
      case (op)
         3'b000: e.result = (a == b);
         3'b001: e.result = (a != b);
         3'b100: e.result = ($signed(a) < $signed(b));
         3'b101: e.result = ($signed(a) >= $signed(b));
         3'b110: e.result = (a < b);
         3'b111: e.result = (a >= b);
         default: e.err = 1'b1;
      endcase
      e.lat = NCHUNK;
      if (e.err) begin
         e.lat = 1;
      end else begin
`ifndef CMP_FIXED_LATENCY_EN
         found = 1'b0;
         for (int i = NCHUNK - 1; i >= 0; i--) begin
            if (!found && (a[i*CHUNK +: CHUNK] != b[i*CHUNK +: CHUNK])) begin
               found = 1'b1;
               e.lat = NCHUNK - i;
            end
         end
`else
         found = 1'b0;
`endif
      end
      return e;
   endfunction

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag, input int hold);
      exp_t e;
      int   lat;
      @(negedge clk);
      check({tag, ".in_ready_pre"}, 32'(bus.in_ready), 1);
      bus.in_valid  = 1'b1;
      bus.a         = a;
      bus.b         = b;
      bus.cmp_op    = op;
      bus.out_ready = (hold == 0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      sb_q.push_back(model(op, a, b, tag));
      lat = 0;
      while (!bus.out_valid && lat < 4 * NCHUNK) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, ".out_valid"}, 32'(bus.out_valid), 1);
      e = sb_q.pop_front();
      check({e.tag, ".result"}, 32'(bus.result), 32'(e.result));
      check({e.tag, ".err"}, 32'(bus.err), 32'(e.err));
      check({e.tag, ".latency"}, lat, e.lat);
      for (int i = 0; i < hold; i++) begin
         bus.in_valid = 1'b1;
         bus.a        = $urandom;
         bus.b        = $urandom;
         bus.cmp_op   = 3'b001;
         @(posedge clk); #1;
         check({tag, ".hold_valid"}, 32'(bus.out_valid), 1);
         check({tag, ".hold_result"}, 32'(bus.result), 32'(e.result));
         check({tag, ".hold_err"}, 32'(bus.err), 32'(e.err));
         check({tag, ".hold_in_ready"}, 32'(bus.in_ready), 0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check({tag, ".post_valid"}, 32'(bus.out_valid), 0);
      check({tag, ".post_in_ready"}, 32'(bus.in_ready), 1);
   endtask

   logic [2:0] op_tab [8];
   logic [31:0] ra, rb;
   logic [2:0]  rop;

   initial begin
      op_tab = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b011};
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cmp_op    = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst.in_ready", 32'(bus.in_ready), 1);
      check("rst.out_valid", 32'(bus.out_valid), 0);
      check("rst.busy", 32'(bus.busy), 0);
      check("rst.result", 32'(bus.result), 0);
      check("rst.err", 32'(bus.err), 0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(3'b000, 32'h1234_5678, 32'h1234_5678, "eq_same", 0);
      run_op(3'b001, 32'h1234_5678, 32'h1234_5678, "ne_same", 0);
      run_op(3'b100, 32'hFFFF_FFFF, 32'h0000_0001, "lt_neg", 0);
      run_op(3'b110, 32'hFFFF_FFFF, 32'h0000_0001, "ltu_big", 0);
      run_op(3'b111, 32'h0000_0100, 32'h0000_00FF, "geu_s1", 0);
      run_op(3'b101, 32'h8000_0000, 32'h7FFF_FFFF, "ge_minmax", 0);
      run_op(3'b100, 32'h8000_0000, 32'h7FFF_FFFF, "lt_minmax", 0);
      run_op(3'b110, 32'h0000_0000, 32'h0000_0001, "ltu_s0", 0);
      run_op(3'b000, 32'h1234_5678, 32'h1234_5679, "eq_diff_low", 0);
      run_op(3'b101, 32'h0000_0005, 32'h0000_0005, "ge_equal", 0);

      run_op(3'b110, 32'h0000_0010, 32'h0000_0020, "bp_ltu", 5);

      run_op(3'b010, 32'h0000_0001, 32'h0000_0002, "illegal_010", 0);
      run_op(3'b011, 32'h0000_0001, 32'h0000_0002, "illegal_011", 0);
      run_op(3'b100, 32'h0000_0001, 32'h0000_0002, "legal_after_illegal", 0);

      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = 32'h1234_5678;
      bus.b        = 32'h1234_5678;
      bus.cmp_op   = 3'b000;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      check("abort.busy_before", 32'(bus.busy), 1);
      rst_n = 1'b0;
      #1;
      check("abort.out_valid", 32'(bus.out_valid), 0);
      check("abort.in_ready", 32'(bus.in_ready), 1);
      check("abort.busy", 32'(bus.busy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < NCHUNK + 2; i++) begin
         @(posedge clk); #1;
         check("abort.no_output", 32'(bus.out_valid), 0);
      end
      run_op(3'b100, 32'd2, 32'd3, "lt_after_reset", 0);

      for (int i = 0; i < 16; i++) begin
         rop = op_tab[$urandom_range(7, 0)];
         ra  = $urandom;
         case ($urandom_range(2, 0))
            0: rb = ra;
            1: rb = ra ^ (32'd1 << $urandom_range(31, 0));
            default: rb = $urandom;
         endcase
         run_op(rop, ra, rb, $sformatf("rand%0d", i), (i % 4 == 3) ? 2 : 0);
      end

      check("sb.empty", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/iterative_comparator.md
Name: iterative_comparator

Overview:
Parametrised, multi-cycle integer comparator for the branch/set-less-than path. It compares two WIDTH-bit operands in CHUNK-bit slices, starting at the MSB, and exits early on the first differing slice. It supports all six RISC-V branch conditions (funct3 encoding). It sits between operand read and branch resolution, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, operand width in bits.
- CHUNK, 8, bits compared per cycle. Must divide WIDTH. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and op present.
- in_ready  out  1  block can accept. Equals (state==IDLE).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cmp_op  in  3  000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU. 010/011 are illegal.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  1  condition true.
- err  out  1  illegal cmp_op was accepted.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, out_valid=0, result=0, err=0, busy=0.
  - Slice index and operand registers cleared.
  - in_ready=1 while in reset, since state is IDLE.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - Accept on the clk edge where in_valid && in_ready.
  - Latch a, b, cmp_op. Set idx=NCHUNK-1.
  - Legal op -> SCAN. Illegal op -> DONE with err=1, result=0.
- SCAN, one slice per cycle:
  - sa=a[idx*CHUNK +: CHUNK], sb likewise.
  - For signed ops (LT/GE) at idx==NCHUNK-1, invert the MSB of both slices before an unsigned slice compare.
  - Slices differ: record lt=(sa<sb), eq=0, go to DONE.
  - Slices equal and idx==0: eq=1, lt=0, go to DONE.
  - Otherwise idx decrements and the state stays SCAN.
- Result mapping, registered on entry to DONE:
  - EQ=eq, NE=!eq.
  - LT/LTU=lt, GE/GEU=!lt.
- DONE:
  - out_valid=1. result and err held stable until out_valid && out_ready.
  - On that edge: -> IDLE, out_valid=0.
  - No new input is accepted in the same cycle; in_ready rises the cycle after the output handshake.
- Latency, in cycles from the accept edge to out_valid high:
  - k, where k = number of slices scanned (1..NCHUNK).
  - Illegal op: 1.
  - Throughput at most one op per latency+1 cycles.
- Boundaries:
  - Equal operands always scan NCHUNK slices.
  - Most-negative vs most-positive resolves in the top slice (signed).
  - idx does not wrap below 0.
  - Reset mid-SCAN or mid-DONE aborts the op with no output produced.
  - in_valid while busy is ignored, with no latching. The source holds in_valid under ready/valid rules.
- Width rules: result is 1 bit. No arithmetic subtraction; comparison is slice-wise only.

Optional Feature:
- Macro CMP_FIXED_LATENCY_EN.
- Defined:
  - Early exit is disabled; the first difference is recorded and the scan continues to idx==0.
  - Latency is always NCHUNK for legal ops, for data-independent timing.
  - err and illegal-op latency are unchanged.
- Undefined: early exit as described above.

Test Plan:
- EQ, a=b=0x1234_5678 (WIDTH=32, CHUNK=8) -> result=1, err=0, latency 4. Same operands with NE -> result=0.
- LT, a=0xFFFF_FFFF, b=0x0000_0001 -> result=1, latency 1. LTU with the same operands -> result=0, latency 1. With CMP_FIXED_LATENCY_EN, both have latency 4 and the same results.
- GEU, a=0x0000_0100, b=0x0000_00FF -> result=1, latency 3 (slice 1 differs). GE, a=0x8000_0000, b=0x7FFF_FFFF -> result=0, latency 1.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid, result and err stable, in_ready=0, in_valid pulses ignored. After out_ready=1 -> out_valid=0 next cycle, in_ready=1.
- rst_n low for 1 cycle during SCAN of an EQ op -> out_valid=0 and in_ready=1 immediately. After release, a new LT op (a=2, b=3) yields result=1 normally.
- cmp_op=010 -> err=1, result=0, latency 1. The next legal op has err=0.
